// File: rtl/cxu_accum.sv
// cxu_accum: fixed-latency CXU with four 32-bit accumulator contexts.
// Optional signed saturation with macro CXU_ACCUM_SATURATE_EN.
//
// Ports:
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous active-high reset
//   cxu_req_valid   in   1   request strobe
//   cxu_data0_i     in  32   operand 0
//   cxu_data1_i     in  32   operand 1
//   cx_state_id_i   in   2   context selector
//   cx_func_i       in  25   function code, bits [2:0] decoded
//   cxu_req_ready   out  1   high in IDLE
//   cxu_resp_valid  out  1   one-cycle response strobe
//   cxu_resp_data   out 32   response data, held between responses
//   cxu_resp_status out  4   bit0 saturated, bit1 illegal function
//
// Functions: 0 ADD, 1 SUB, 2 ACC, 3 READ, 4 WRITE, 5 CLEAR, 6/7 illegal.

module cxu_accum #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cxu_req_valid,
    input  logic [31:0] cxu_data0_i,
    input  logic [31:0] cxu_data1_i,
    input  logic [1:0]  cx_state_id_i,
    input  logic [24:0] cx_func_i,
    output logic        cxu_req_ready,
    output logic        cxu_resp_valid,
    output logic [31:0] cxu_resp_data,
    output logic [3:0]  cxu_resp_status
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    localparam logic [2:0] F_ADD   = 3'd0;
    localparam logic [2:0] F_SUB   = 3'd1;
    localparam logic [2:0] F_ACC   = 3'd2;
    localparam logic [2:0] F_READ  = 3'd3;
    localparam logic [2:0] F_WRITE = 3'd4;
    localparam logic [2:0] F_CLEAR = 3'd5;

    localparam logic [3:0] ST_OK      = 4'b0000;
    localparam logic [3:0] ST_ILLEGAL = 4'b0010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [31:0] op_d0_q, op_d0_d;
    logic [31:0] op_d1_q, op_d1_d;
    logic [1:0]  op_sid_q, op_sid_d;
    logic [2:0]  op_func_q, op_func_d;

    logic [31:0] ctx_q [4];
    logic [31:0] resp_data_q;
    logic [3:0]  resp_status_q;

    logic        accept;
    logic        finish;

    logic [31:0] res_data;
    logic [3:0]  res_status;
    logic        ctx_we;
    logic [31:0] ctx_wdata;
    logic [31:0] ctx_cur;
    logic [32:0] add_r;
    logic [32:0] sub_r;
    logic [32:0] acc_r;

    // Upper function bits carry no meaning for this unit.
    logic        unused_func;
    assign unused_func = ^cx_func_i[24:3];

    // Returns {saturated, result} for a signed add or subtract.
    function automatic logic [32:0] arith(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sub
    );
`ifdef CXU_ACCUM_SATURATE_EN
        logic [32:0] s;
        s = sub ? ({a[31], a} - {b[31], b})
                : ({a[31], a} + {b[31], b});
        // Sign of the 33-bit result disagrees with bit 31 on overflow.
        if (s[32] != s[31]) begin
            return {1'b1, s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF};
        end
        return {1'b0, s[31:0]};
`else
        return {1'b0, sub ? (a - b) : (a + b)};
`endif
    endfunction

    assign accept = (state_q == IDLE) && cxu_req_valid;
    assign finish = (state_q == BUSY) && (cnt_q == 4'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cxu_req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        cxu_req_ready  = 1'b0;
        cxu_resp_valid = 1'b0;
        unique case (state_q)
            IDLE:    cxu_req_ready  = 1'b1;
            RESP:    cxu_resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign cxu_resp_data   = resp_data_q;
    assign cxu_resp_status = resp_status_q;

    // Operand capture on acceptance
    always_comb begin
        op_d0_d   = op_d0_q;
        op_d1_d   = op_d1_q;
        op_sid_d  = op_sid_q;
        op_func_d = op_func_q;
        if (accept) begin
            op_d0_d   = cxu_data0_i;
            op_d1_d   = cxu_data1_i;
            op_sid_d  = cx_state_id_i;
            op_func_d = cx_func_i[2:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_d0_q   <= 32'd0;
            op_d1_q   <= 32'd0;
            op_sid_q  <= 2'd0;
            op_func_q <= 3'd0;
        end else begin
            op_d0_q   <= op_d0_d;
            op_d1_q   <= op_d1_d;
            op_sid_q  <= op_sid_d;
            op_func_q <= op_func_d;
        end
    end

    // Execute: result and context update for the captured request
    assign ctx_cur = ctx_q[op_sid_q];
    assign add_r   = arith(op_d0_q, op_d1_q, 1'b0);
    assign sub_r   = arith(op_d0_q, op_d1_q, 1'b1);
    assign acc_r   = arith(ctx_cur, op_d0_q, 1'b0);

    always_comb begin
        res_data   = 32'd0;
        res_status = ST_OK;
        ctx_we     = 1'b0;
        ctx_wdata  = 32'd0;
        unique case (op_func_q)
            F_ADD: begin
                res_data   = add_r[31:0];
                res_status = {3'b000, add_r[32]};
            end
            F_SUB: begin
                res_data   = sub_r[31:0];
                res_status = {3'b000, sub_r[32]};
            end
            F_ACC: begin
                res_data   = acc_r[31:0];
                res_status = {3'b000, acc_r[32]};
                ctx_we     = 1'b1;
                ctx_wdata  = acc_r[31:0];
            end
            F_READ: begin
                res_data = ctx_cur;
            end
            F_WRITE: begin
                res_data  = ctx_cur;
                ctx_we    = 1'b1;
                ctx_wdata = op_d0_q;
            end
            F_CLEAR: begin
                res_data  = ctx_cur;
                ctx_we    = 1'b1;
                ctx_wdata = 32'd0;
            end
            default: begin
                res_status = ST_ILLEGAL;
            end
        endcase
    end

    // Context and response registers commit on the edge entering RESP,
    // so a reset during BUSY discards the operation entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                ctx_q[i] <= 32'd0;
            end
            resp_data_q   <= 32'd0;
            resp_status_q <= 4'd0;
        end else if (finish) begin
            if (ctx_we) begin
                ctx_q[op_sid_q] <= ctx_wdata;
            end
            resp_data_q   <= res_data;
            resp_status_q <= res_status;
        end
    end

endmodule

// File: tb/tb_cxu_accum.sv
// tb_cxu_accum: randomized and directed checks of cxu_accum
// against an arithmetic reference model of the contexts.

module tb_cxu_accum;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cxu_req_valid = 1'b0;
    logic [31:0] cxu_data0_i = '0;
    logic [31:0] cxu_data1_i = '0;
    logic [1:0]  cx_state_id_i = '0;
    logic [24:0] cx_func_i = '0;
    logic        cxu_req_ready;
    logic        cxu_resp_valid;
    logic [31:0] cxu_resp_data;
    logic [3:0]  cxu_resp_status;

    int checks = 0;
    int failures = 0;

    logic [31:0] mctx [4];

    typedef struct packed {
        logic [2:0]  f;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] b;
    } op_t;

    cxu_accum #(.LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .cxu_req_valid   (cxu_req_valid),
        .cxu_data0_i     (cxu_data0_i),
        .cxu_data1_i     (cxu_data1_i),
        .cx_state_id_i   (cx_state_id_i),
        .cx_func_i       (cx_func_i),
        .cxu_req_ready   (cxu_req_ready),
        .cxu_resp_valid  (cxu_resp_valid),
        .cxu_resp_data   (cxu_resp_data),
        .cxu_resp_status (cxu_resp_status)
    );

    always #5 clk = ~clk;

    // Fit a mathematically exact signed value into 32 bits.
    function automatic logic [31:0] fit(input longint v, output bit sat);
        logic [63:0] u;
        sat = 1'b0;
`ifdef CXU_ACCUM_SATURATE_EN
        if (v > 64'sd2147483647) begin
            sat = 1'b1;
            return 32'h7FFF_FFFF;
        end
        if (v < -64'sd2147483648) begin
            sat = 1'b1;
            return 32'h8000_0000;
        end
`endif
        u = 64'(v);
        return u[31:0];
    endfunction

    function automatic void model(
        input  logic [2:0]  f,
        input  logic [1:0]  s,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] ed,
        output logic [3:0]  es
    );
        longint sa, sb, sc;
        bit     sat;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sc  = longint'($signed(mctx[s]));
        sat = 1'b0;
        es  = 4'd0;
        ed  = 32'd0;
        case (f)
            3'd0: begin ed = fit(sa + sb, sat); es = {3'b0, sat}; end
            3'd1: begin ed = fit(sa - sb, sat); es = {3'b0, sat}; end
            3'd2: begin
                ed = fit(sc + sa, sat);
                es = {3'b0, sat};
                mctx[s] = ed;
            end
            3'd3: ed = mctx[s];
            3'd4: begin ed = mctx[s]; mctx[s] = a; end
            3'd5: begin ed = mctx[s]; mctx[s] = 32'd0; end
            default: begin ed = 32'd0; es = 4'b0010; end
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) mctx[i] = 32'd0;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h7FFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 15)));
            default: return $urandom();
        endcase
    endfunction

    // Drive one request from IDLE and observe the response; no checking.
    task automatic send(
        input  logic [2:0]  f,
        input  logic [1:0]  s,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output int          lat,
        output logic [31:0] d,
        output logic [3:0]  st,
        output logic        av,
        output logic [31:0] ad
    );
        int w = 0;
        while (!cxu_req_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        cxu_req_valid = 1'b1;
        cxu_data0_i   = a;
        cxu_data1_i   = b;
        cx_state_id_i = s;
        cx_func_i     = {22'($urandom()), f};
        @(posedge clk); #1;
        cxu_req_valid = 1'b0;
        lat = -1;
        for (int i = 0; i <= 20 && lat < 0; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            if (cxu_resp_valid) lat = i;
        end
        d  = cxu_resp_data;
        st = cxu_resp_status;
        @(posedge clk); #1;
        av = cxu_resp_valid;
        ad = cxu_resp_data;
    endtask

    task automatic test_reset();
        int lat;
        logic [31:0] d, ad, ed;
        logic [3:0]  st, es;
        logic        av;
        #1;
        checks++;
        if ({cxu_req_ready, cxu_resp_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_hs got=%b exp=10",
                     {cxu_req_ready, cxu_resp_valid});
        end
        checks++;
        if ({cxu_resp_data, cxu_resp_status} !== 36'd0) begin
            failures++;
            $display("FAIL reset_out got=%h/%h exp=0/0",
                     cxu_resp_data, cxu_resp_status);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send(3'd0, 2'd0, 32'd5, 32'd1, lat, d, st, av, ad);
        model(3'd0, 2'd0, 32'd5, 32'd1, ed, es);
        checks++;
        if (lat !== LAT || d !== 32'd6 || st !== 4'd0) begin
            failures++;
            $display("FAIL first_add got=%0d/%h/%h exp=%0d/6/0",
                     lat, d, st, LAT);
        end
        // Asynchronous assertion mid-cycle.
        rst = 1'b1;
        #1;
        checks++;
        if (cxu_resp_data !== 32'd0 || cxu_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_rst got=%h/%b exp=0/1",
                     cxu_resp_data, cxu_req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_directed();
        op_t ops [14];
        int lat;
        logic [31:0] d, ad, ed;
        logic [3:0]  st, es;
        logic        av;
        ops = '{
            '{3'd0, 2'd0, 32'd5, 32'd1},
            '{3'd4, 2'd1, 32'd10, 32'd0},
            '{3'd2, 2'd1, 32'd7, 32'd0},
            '{3'd3, 2'd1, 32'd0, 32'd0},
            '{3'd3, 2'd0, 32'd0, 32'd0},
            '{3'd4, 2'd3, 32'hDEAD_BEEF, 32'd0},
            '{3'd6, 2'd1, 32'd1, 32'd2},
            '{3'd3, 2'd0, 32'd0, 32'd0},
            '{3'd3, 2'd1, 32'd0, 32'd0},
            '{3'd3, 2'd2, 32'd0, 32'd0},
            '{3'd3, 2'd3, 32'd0, 32'd0},
            '{3'd7, 2'd3, 32'd9, 32'd9},
            '{3'd0, 2'd0, 32'h7FFF_FFFF, 32'd1},
            '{3'd1, 2'd0, 32'h8000_0000, 32'd1}
        };
        foreach (ops[i]) begin
            send(ops[i].f, ops[i].s, ops[i].a, ops[i].b,
                 lat, d, st, av, ad);
            model(ops[i].f, ops[i].s, ops[i].a, ops[i].b, ed, es);
            checks++;
            if (lat !== LAT) begin
                failures++;
                $display("FAIL dir%0d_lat got=%0d exp=%0d", i, lat, LAT);
            end
            checks++;
            if (d !== ed || st !== es) begin
                failures++;
                $display("FAIL dir%0d_data got=%h/%h exp=%h/%h",
                         i, d, st, ed, es);
            end
            checks++;
            if (av !== 1'b0 || ad !== ed) begin
                failures++;
                $display("FAIL dir%0d_hold got=%b/%h exp=0/%h",
                         i, av, ad, ed);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int n = 0;
        logic [31:0] got = 32'd0;
        cxu_req_valid = 1'b1;
        cxu_data0_i   = 32'd5;
        cxu_data1_i   = 32'd1;
        cx_state_id_i = 2'd0;
        cx_func_i     = 25'd0;
        @(posedge clk); #1;
        cxu_data0_i = 32'd99;
        checks++;
        if (cxu_req_ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready got=%b exp=0", cxu_req_ready);
        end
        for (int i = 1; i <= LAT + 4; i++) begin
            @(posedge clk); #1;
            if (cxu_resp_valid) begin
                n++;
                got = cxu_resp_data;
            end
            if (i == LAT + 1) cxu_req_valid = 1'b0;
        end
        checks++;
        if (n !== 1 || got !== 32'd6) begin
            failures++;
            $display("FAIL busy_ignore got=%0d/%h exp=1/6", n, got);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [31:0] d, ad, ed;
        logic [3:0]  st, es;
        logic        av;
        send(3'd4, 2'd2, 32'h55, 32'd0, lat, d, st, av, ad);
        model(3'd4, 2'd2, 32'h55, 32'd0, ed, es);
        cxu_req_valid = 1'b1;
        cxu_data0_i   = 32'd3;
        cx_state_id_i = 2'd2;
        cx_func_i     = 25'd2;
        @(posedge clk); #1;
        cxu_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (cxu_resp_valid !== 1'b0 || cxu_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_state got=%b/%b exp=0/1",
                     cxu_resp_valid, cxu_req_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send(3'd3, 2'd2, 32'd0, 32'd0, lat, d, st, av, ad);
        model(3'd3, 2'd2, 32'd0, 32'd0, ed, es);
        checks++;
        if (lat !== LAT || d !== ed || st !== es) begin
            failures++;
            $display("FAIL abort_read got=%0d/%h/%h exp=%0d/%h/%h",
                     lat, d, st, LAT, ed, es);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2:0]  f;
        logic [1:0]  s;
        logic [31:0] a, b, d, ad, ed;
        logic [3:0]  st, es;
        logic        av;
        for (int i = 0; i < 80; i++) begin
            f = 3'($urandom_range(0, 7));
            s = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            send(f, s, a, b, lat, d, st, av, ad);
            model(f, s, a, b, ed, es);
            checks++;
            if (lat !== LAT || av !== 1'b0) begin
                failures++;
                $display("FAIL rnd%0d_timing got=%0d/%b exp=%0d/0",
                         i, lat, av, LAT);
            end
            checks++;
            if (d !== ed || st !== es || ad !== ed) begin
                failures++;
                $display("FAIL rnd%0d_f%0d got=%h/%h/%h exp=%h/%h",
                         i, f, d, st, ad, ed, es);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cxu_accum.md
CXU_ACCUM -- requirements
Module: cxu_accum

Interface
REQ-001 SHALL have parameter LATENCY, default 2, meaning clock edges from request acceptance to the response-valid rising edge (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cxu_req_valid  input  1  request strobe from the switch (the switch's cxu_requesting bit for this CXU).
REQ-005 SHALL have port cxu_data0_i  input  32  operand 0.
REQ-006 SHALL have port cxu_data1_i  input  32  operand 1.
REQ-007 SHALL have port cx_state_id_i  input  2  state context selector (4 contexts).
REQ-008 SHALL have port cx_func_i  input  25  function code; only bits [2:0] are decoded, bits [24:3] are ignored.
REQ-009 SHALL have port cxu_req_ready  output  1  high when a request can be accepted.
REQ-010 SHALL have port cxu_resp_valid  output  1  response strobe to the switch (the switch's cxu_replying bit).
REQ-011 SHALL have port cxu_resp_data  output  32  response data.
REQ-012 SHALL have port cxu_resp_status  output  4  response status: 0 OK; bit0 saturated; bit1 illegal function.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY and RESP; cxu_req_ready SHALL be 1 only in IDLE.
REQ-014 In IDLE, a rising edge with cxu_req_valid=1 SHALL capture data0, data1, state_id and func[2:0], load the counter with LATENCY-1, and enter BUSY.
REQ-015 BUSY SHALL decrement the counter each edge and move to RESP on the edge at which the counter is 0; cxu_req_valid SHALL be ignored in BUSY and RESP.
REQ-016 cxu_resp_valid SHALL rise exactly LATENCY edges after the accepting edge, stay high for exactly one cycle (RESP), and the FSM SHALL then return to IDLE; there is no backpressure.
REQ-017 cxu_resp_data and cxu_resp_status SHALL be valid while cxu_resp_valid=1 and SHALL hold their last values otherwise.
REQ-018 func 0 ADD SHALL return d0+d1; context untouched.
REQ-019 func 1 SUB SHALL return d0-d1; context untouched.
REQ-020 func 2 ACC SHALL set ctx[sid]=ctx[sid]+d0 and return the new value.
REQ-021 func 3 READ SHALL return ctx[sid].
REQ-022 func 4 WRITE SHALL set ctx[sid]=d0 and return the old value.
REQ-023 func 5 CLEAR SHALL set ctx[sid]=0 and return the old value.
REQ-024 func 6 and func 7 SHALL return data 0 with status 4'b0010 and SHALL leave all contexts unchanged.
REQ-025 Context writes SHALL commit on the edge entering RESP, so a request accepted in the following IDLE cycle sees the updated value.
REQ-026 All arithmetic SHALL be 32-bit two's complement; the default (see REQ-031) is modulo-2^32 wrap with status 0.

Reset
REQ-027 While rst=1, the FSM SHALL be IDLE, the counter 0, all four contexts 0, cxu_resp_valid 0, cxu_resp_data 0 and cxu_resp_status 0, taking effect immediately without waiting for a clock edge.
REQ-028 Reset asserted in BUSY or RESP SHALL abort the operation with no context update and no response pulse.
REQ-029 The first request SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 With macro CXU_ACCUM_SATURATE_EN defined, ADD, SUB and ACC SHALL saturate signed results to 0x7FFFFFFF or 0x80000000 and set status bit0 on overflow; a saturated ACC result is also stored into the context.
REQ-031 Without CXU_ACCUM_SATURATE_EN, those operations SHALL wrap modulo 2^32 and status bit0 SHALL always be 0.

Verification
REQ-032 LATENCY=2: ADD with d0=5, d1=1 accepted at edge E0 -> resp_valid=1 at E0+2 for one cycle, data=6, status=0.
REQ-033 WRITE sid=1, d0=10, then ACC sid=1, d0=7, then READ sid=1 -> responses 0, 17, 17; READ sid=0 -> 0.
REQ-034 func=6 -> data=0, status=2; a following READ on every sid returns its prior value.
REQ-035 Request during BUSY (valid held high, d0=99) -> ignored; exactly one response, for the first request.
REQ-036 rst pulsed one cycle after accepting ACC sid=2, d0=3 -> no resp_valid; subsequent READ sid=2 -> 0.
REQ-037 ADD 0x7FFFFFFF+1 -> with macro: data 0x7FFFFFFF, status 1; without macro: data 0x80000000, status 0.
